// File: rtl/config_stream_loader_pkg.sv
// Shared widths and helpers for the configuration stream loader.
// Holds the fixed bus widths and the saturating progress increment.
package config_stream_loader_pkg;

   localparam int ADDR_W = 32;
   localparam int PROG_W = 16;

   // Progress never wraps back to zero: it sticks at all-ones.
   function automatic logic [PROG_W-1:0] sat_inc(input logic [PROG_W-1:0] value);
      logic [PROG_W-1:0] result;
      if (value == {PROG_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/config_stream_loader.sv
// Streams configuration words into the fabric's configuration controller,
// assigning flat addresses 0..TOTAL-1 and tracking load progress/completion.
module config_stream_loader
   import config_stream_loader_pkg::*;
#(
   parameter int WIDTH   = 40,
   parameter int STAGES  = 16,
   parameter int LUTSIZE = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              wren_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic [WIDTH-1:0]  data_out,
   output logic              busy,
   output logic [PROG_W-1:0] progress,
   output logic              done
);

   localparam int TOTAL = STAGES << LUTSIZE;
   // One spare bit so the counter can represent TOTAL itself.
   localparam int CNT_W = $clog2(TOTAL) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   count_r;
   logic               wren_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [WIDTH-1:0]   data_r;
   logic [PROG_W-1:0]  progress_r;
   logic               ready_s;
   logic               accept_s;

   assign ready_s  = (state_r == ST_RUN);
   assign accept_s = data_valid && ready_s;

   // Load sequencer: state, word counter and the registered write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         count_r    <= '0;
         wren_r     <= 1'b0;
         addr_r     <= '0;
         data_r     <= '0;
         progress_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               wren_r <= 1'b0;
               if (start) begin
                  state_r    <= ST_RUN;
                  count_r    <= '0;
                  progress_r <= '0;
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  wren_r     <= 1'b1;
                  addr_r     <= ADDR_W'(count_r);
                  data_r     <= data_in;
                  count_r    <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  progress_r <= sat_inc(progress_r);
                  if (count_r == LAST_CNT) begin
                     state_r <= ST_FLUSH;
                  end
               end else begin
                  wren_r <= 1'b0;
               end
            end
            ST_FLUSH: begin
               wren_r  <= 1'b0;
               state_r <= ST_DONE;
            end
            default: begin
               wren_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_ready = ready_s;
   assign wren_out   = wren_r;
   assign addr_out   = addr_r;
   assign data_out   = data_r;
   assign progress   = progress_r;
   assign busy       = (state_r == ST_RUN) || (state_r == ST_FLUSH);
   assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench: a small (8-word) loader against a scoreboard model,
// plus a default-size (1024-word) loader checked for addressing and completion.
module tb_config_stream_loader;

   localparam int W       = 40;
   localparam int S_TOTAL = 8;
   localparam int D_TOTAL = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic          start_s, valid_s, ready_s, wren_s, busy_s, done_s;
   logic [W-1:0]  din_s, dout_s;
   logic [31:0]   addr_s;
   logic [15:0]   prog_s;

   logic          start_d, valid_d, ready_d, wren_d, busy_d, done_d;
   logic [W-1:0]  din_d, dout_d;
   logic [31:0]   addr_d;
   logic [15:0]   prog_d;

   config_stream_loader #(.WIDTH(W), .STAGES(2), .LUTSIZE(2)) dut_small (
      .clk(clk), .reset(reset), .start(start_s), .data_in(din_s),
      .data_valid(valid_s), .data_ready(ready_s), .wren_out(wren_s),
      .addr_out(addr_s), .data_out(dout_s), .busy(busy_s),
      .progress(prog_s), .done(done_s));

   config_stream_loader #(.WIDTH(W)) dut_default (
      .clk(clk), .reset(reset), .start(start_d), .data_in(din_d),
      .data_valid(valid_d), .data_ready(ready_d), .wren_out(wren_d),
      .addr_out(addr_d), .data_out(dout_d), .busy(busy_d),
      .progress(prog_d), .done(done_d));

   int compared   = 0;
   int mismatched = 0;

   // Reference model: load phase, words accepted, and writes still owed.
   typedef struct {
      logic [31:0]  a;
      logic [W-1:0] d;
   } wr_t;
   wr_t          pend[$];
   int           m_phase;   // 0 idle, 1 accepting, 2 one-cycle drain, 3 complete
   int           m_acc;
   logic [31:0]  m_last_addr;
   logic [W-1:0] m_last_data;
   int           pat[7] = '{1, 0, 0, 1, 1, 0, 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] r;
      r = {8'($urandom), 32'($urandom)};
      return r;
   endfunction

   task automatic check_small();
      wr_t wr;
      chk("ready", 64'(ready_s), 64'(m_phase == 1));
      chk("busy", 64'(busy_s), 64'(m_phase == 1 || m_phase == 2));
      chk("done", 64'(done_s), 64'(m_phase == 3));
      chk("progress", 64'(prog_s), 64'(m_acc));
      if (pend.size() > 0) begin
         wr = pend.pop_front();
         m_last_addr = wr.a;
         m_last_data = wr.d;
         chk("wren", 64'(wren_s), 64'd1);
      end else begin
         chk("wren", 64'(wren_s), 64'd0);
      end
      chk("addr", 64'(addr_s), 64'(m_last_addr));
      chk("data", 64'(dout_s), 64'(m_last_data));
   endtask

   // Called at a falling edge: check, drive, advance model, move to next falling edge.
   task automatic step(input logic v, input logic st, input logic [W-1:0] d);
      wr_t wr;
      check_small();
      start_s = st;
      valid_s = v;
      din_s   = d;
      if (m_phase == 1) begin
         if (v) begin
            wr.a = 32'(m_acc);
            wr.d = d;
            pend.push_back(wr);
            m_acc++;
            if (m_acc == S_TOTAL) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         m_phase = 3;
      end else if (st) begin
         m_phase = 1;
         m_acc   = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // pattern 0: continuous valid; 1: bursty. mid: word count at which start is re-pulsed.
   task automatic load(input int pattern, input int mid, input int stop_after);
      int   budget = 200;
      int   idx = 0;
      logic v, st;
      step(1'b0, 1'b1, rand_word());
      while (m_phase != 3 && !(stop_after > 0 && m_acc >= stop_after) && budget > 0) begin
         if (pattern == 0) v = 1'b1;
         else if (idx < 7) v = pat[idx] != 0;
         else v = 1'($urandom_range(1, 0));
         st = (mid >= 0 && m_phase == 1 && m_acc == mid);
         step(v, st, rand_word());
         idx++;
         budget--;
      end
      if (budget == 0) chk("load_timeout_done", 64'(done_s), 64'd1);
      step(1'b0, 1'b0, rand_word());
   endtask

   task automatic reset_pulse();
      start_s = 1'b0;
      valid_s = 1'b0;
      reset   = 1'b0;
      #1;
      chk("rst_wren", 64'(wren_s), 64'd0);
      chk("rst_addr", 64'(addr_s), 64'd0);
      chk("rst_data", 64'(dout_s), 64'd0);
      chk("rst_prog", 64'(prog_s), 64'd0);
      chk("rst_done", 64'(done_s), 64'd0);
      chk("rst_busy", 64'(busy_s), 64'd0);
      chk("rst_ready", 64'(ready_s), 64'd0);
      pend.delete();
      m_phase     = 0;
      m_acc       = 0;
      m_last_addr = '0;
      m_last_data = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b0;
      start_s = 1'b0; valid_s = 1'b0; din_s = '0;
      start_d = 1'b0; valid_d = 1'b0; din_d = '0;
      m_phase = 0; m_acc = 0; m_last_addr = '0; m_last_data = '0;
      #2;
      chk("init_wren", 64'(wren_s), 64'd0);
      chk("init_ready", 64'(ready_s), 64'd0);
      chk("init_done_d", 64'(done_d), 64'd0);
      chk("init_prog_d", 64'(prog_d), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      load(0, -1, 0);                 // full continuous load
      load(1, -1, 0);                 // restart from done, bursty source
      load(0, 3, 0);                  // start re-pulsed mid-load is ignored
      load(0, -1, 5);                 // abort after five words
      step(1'b0, 1'b0, rand_word());
      reset_pulse();
      load(0, -1, 0);                 // reload from address 0 after reset
      load(1, -1, 0);

      // Default-size fabric: 1024 words, last address decodes to stage 15 / LUT 63.
      start_d = 1'b1;
      @(negedge clk);
      start_d = 1'b0;
      chk("d_ready", 64'(ready_d), 64'd1);
      for (int i = 0; i < D_TOTAL; i++) begin
         valid_d = 1'b1;
         din_d   = {8'hA5, 32'(i)};
         @(negedge clk);
         chk("d_wren", 64'(wren_d), 64'd1);
         chk("d_addr", 64'(addr_d), 64'(i));
      end
      valid_d = 1'b0;
      chk("d_data", 64'(dout_d), 64'({8'hA5, 32'(D_TOTAL - 1)}));
      chk("d_prog", 64'(prog_d), 64'(D_TOTAL));
      chk("d_stage", 64'(addr_d >> 6), 64'd15);
      chk("d_lut", 64'(addr_d & 32'd63), 64'd63);
      chk("d_busy_flush", 64'(busy_d), 64'd1);
      @(negedge clk);
      chk("d_wren_end", 64'(wren_d), 64'd0);
      chk("d_done", 64'(done_d), 64'd1);
      chk("d_busy_end", 64'(busy_d), 64'd0);
      chk("d_prog_end", 64'(prog_d), 64'(D_TOTAL));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
